// File: rtl/sb_pkg.sv
// Shared types and helpers for the MEM-stage store buffer.
package sb_pkg;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    OVL_NONE    = 2'b00,
    OVL_EXACT   = 2'b01,
    OVL_PARTIAL = 2'b10
  } ovl_e;

  // Classify how a load word at a overlaps a buffered store word at b (modulo 2^AW).
  function automatic logic [1:0] overlap(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW-1:0] diff;
    diff = a - b;
    if (diff == '0) begin
      return OVL_EXACT;
    end
    if ((diff <= AW'(3)) || (diff >= (AW'(0) - AW'(3)))) begin
      return OVL_PARTIAL;
    end
    return OVL_NONE;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline/memory-facing signal bundle of the store buffer.
interface store_buffer_if;
  import sb_pkg::*;

  logic          st_valid;
  logic [AW-1:0] st_adr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          ld_req;
  logic [AW-1:0] ld_adr;
  logic [DW-1:0] ld_data;
  logic          ld_stall;
  logic          empty;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_rdata;

  // Pipeline plus data memory side.
  modport master (
    output st_valid, st_adr, st_data, ld_req, ld_adr, mem_rdata,
    input  st_ready, ld_data, ld_stall, empty, mem_adr, mem_wdata, mem_write, mem_read
  );

  // Store buffer side.
  modport slave (
    input  st_valid, st_adr, st_data, ld_req, ld_adr, mem_rdata,
    output st_ready, ld_data, ld_stall, empty, mem_adr, mem_wdata, mem_write, mem_read
  );

endinterface

// File: rtl/sb_match.sv
// Load-address lookup over buffered stores: youngest exact hit wins, any partial overlap flags.
module sb_match
  import sb_pkg::*;
(
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      valid,
  input  logic [PTR_W-1:0]      tail,
  input  logic [AW-1:0]         ldAdr,
  output logic                  hit,
  output logic                  partial,
  output logic [DW-1:0]         fwdData
);

  logic [PTR_W-1:0] idx;
  logic [1:0]       ovl;

  // Walk from tail (oldest slot) round to tail-1 (youngest) so later hits overwrite older ones.
  always_comb begin
    hit     = 1'b0;
    partial = 1'b0;
    fwdData = '0;
    idx     = '0;
    ovl     = OVL_NONE;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = tail + PTR_W'(i);
      ovl = overlap(ldAdr, entries[idx].adr);
      if (valid[idx]) begin
        if (ovl == OVL_EXACT) begin
          hit     = 1'b1;
          fwdData = entries[idx].data;
        end else if (ovl == OVL_PARTIAL) begin
          partial = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO between MEM stage and data memory with load forwarding and drain-on-idle-port.
module store_buffer
  import sb_pkg::*;
(
  input logic          clk,
  input logic          rst,
  store_buffer_if.slave sb
);

  sb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic          fwdHit;
  logic          fwdPartial;
  logic [DW-1:0] fwdData;
  logic          doEnq;
  logic          doDrain;

  sb_match uMatch (
    .entries (entries),
    .valid   (valid),
    .tail    (tail),
    .ldAdr   (sb.ld_adr),
    .hit     (fwdHit),
    .partial (fwdPartial),
    .fwdData (fwdData)
  );

  // Acceptance, drain decision and occupancy flag.
  always_comb begin
    sb.st_ready = (count != CNT_W'(DEPTH)) && !(sb.st_valid && sb.ld_req);
    sb.empty    = (count == '0);
    doEnq       = sb.st_valid && sb.st_ready;
    doDrain     = (count != '0) && !sb.ld_req && !rst;
  end

  // Memory port mux: a load owns the port, otherwise the head entry drains.
  always_comb begin
    sb.mem_write = doDrain;
    sb.mem_read  = 1'b0;
    sb.mem_adr   = entries[head].adr;
    sb.mem_wdata = entries[head].data;
    sb.ld_data   = '0;
    sb.ld_stall  = 1'b0;
    if (sb.ld_req) begin
      if (fwdPartial) begin
        sb.ld_stall = 1'b1;
      end else if (fwdHit) begin
        sb.ld_data = fwdData;
      end else begin
        sb.mem_read = 1'b1;
        sb.mem_adr  = sb.ld_adr;
        sb.ld_data  = sb.mem_rdata;
      end
    end
  end

  // Pointer, count and valid-bit update; reset drops every pending store.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (doEnq) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      if (doDrain) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      if (doEnq && !doDrain) begin
        count <= count + CNT_W'(1);
      end else if (!doEnq && doDrain) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Entry payload storage; contents are meaningful only while the valid bit is set.
  always_ff @(posedge clk) begin
    if (doEnq && !rst) begin
      entries[tail] <= '{adr: sb.st_adr, data: sb.st_data};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
  import sb_pkg::*;

  logic clk = 1'b0;
  logic rst;

  store_buffer_if sbIf ();

  store_buffer dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbIf.slave)
  );

  always #5 clk = ~clk;

  // 256-byte memory image aliased by the low address byte; envMem is what the DUT writes.
  logic [7:0] envMem [256];
  logic [7:0] refMem [256];
  sb_entry_t  refQ [$];

  int testsRun    = 0;
  int testsFailed = 0;

  wire [7:0] rdA = sbIf.mem_adr[7:0];
  assign sbIf.mem_rdata = {envMem[rdA + 8'd3], envMem[rdA + 8'd2], envMem[rdA + 8'd1], envMem[rdA]};

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refRead(input logic [31:0] adr);
    logic [7:0] a;
    a = adr[7:0];
    return {refMem[a + 8'd3], refMem[a + 8'd2], refMem[a + 8'd1], refMem[a]};
  endfunction

  function automatic logic [31:0] envRead(input logic [31:0] adr);
    logic [7:0] a;
    a = adr[7:0];
    return {envMem[a + 8'd3], envMem[a + 8'd2], envMem[a + 8'd1], envMem[a]};
  endfunction

  // One clock: drive inputs, predict outputs, compare at negedge, advance model at posedge.
  task automatic doCycle(input logic stV, input logic [31:0] stA, input logic [31:0] stD,
                         input logic ldR, input logic [31:0] ldA, input logic r);
    logic        expReady, expStall, expRead, expWrite, fwdFound;
    logic [31:0] expData, expAdr, expWdata;
    logic        wSeen;
    logic [31:0] wAdr, wData;
    logic [7:0]  b;
    int          n, d;
    sb_entry_t   e;

    sbIf.st_valid = stV;
    sbIf.st_adr   = stA;
    sbIf.st_data  = stD;
    sbIf.ld_req   = ldR;
    sbIf.ld_adr   = ldA;
    rst           = r;

    n        = refQ.size();
    expReady = (n != int'(DEPTH)) && !(stV && ldR);
    expStall = 1'b0;
    expRead  = 1'b0;
    expWrite = 1'b0;
    expData  = '0;
    expAdr   = '0;
    expWdata = '0;
    fwdFound = 1'b0;
    if (ldR) begin
      for (int k = n - 1; k >= 0; k--) begin
        d = int'(ldA - refQ[k].adr);
        if (d != 0 && d >= -3 && d <= 3) begin
          expStall = 1'b1;
        end else if (d == 0 && !fwdFound) begin
          fwdFound = 1'b1;
          expData  = refQ[k].data;
        end
      end
      if (expStall) begin
        expData = '0;
      end else if (!fwdFound) begin
        expRead = 1'b1;
        expAdr  = ldA;
        expData = refRead(ldA);
      end
    end else if (n > 0 && !r) begin
      expWrite = 1'b1;
      expAdr   = refQ[0].adr;
      expWdata = refQ[0].data;
    end

    @(negedge clk);
    checkVal("mem_write", 32'(sbIf.mem_write), 32'(expWrite));
    if (!r) begin
      checkVal("empty", 32'(sbIf.empty), 32'(n == 0));
      checkVal("st_ready", 32'(sbIf.st_ready), 32'(expReady));
      checkVal("ld_stall", 32'(sbIf.ld_stall), 32'(expStall));
      checkVal("mem_read", 32'(sbIf.mem_read), 32'(expRead));
      checkVal("ld_data", sbIf.ld_data, expData);
      if (expRead || expWrite) checkVal("mem_adr", sbIf.mem_adr, expAdr);
      if (expWrite) checkVal("mem_wdata", sbIf.mem_wdata, expWdata);
    end
    wSeen = sbIf.mem_write;
    wAdr  = sbIf.mem_adr;
    wData = sbIf.mem_wdata;

    @(posedge clk);
    if (wSeen === 1'b1) begin
      b = wAdr[7:0];
      envMem[b]         = wData[7:0];
      envMem[b + 8'd1]  = wData[15:8];
      envMem[b + 8'd2]  = wData[23:16];
      envMem[b + 8'd3]  = wData[31:24];
    end
    if (r) begin
      refQ.delete();
    end else begin
      if (expWrite) begin
        e = refQ.pop_front();
        b = e.adr[7:0];
        refMem[b]        = e.data[7:0];
        refMem[b + 8'd1] = e.data[15:8];
        refMem[b + 8'd2] = e.data[23:16];
        refMem[b + 8'd3] = e.data[31:24];
      end
      if (stV && expReady) refQ.push_back('{adr: stA, data: stD});
    end
    #1;
  endtask

  task automatic idle();
    doCycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] dt);
    doCycle(1'b1, a, dt, 1'b0, '0, 1'b0);
  endtask

  task automatic load(input logic [31:0] a);
    doCycle(1'b0, '0, '0, 1'b1, a, 1'b0);
  endtask

  function automatic logic [31:0] randAdr();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 7));
    return 32'($urandom_range(0, 63));
  endfunction

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [31:0] preWord;
    int          diffs;
    int unsigned op;

    rst           = 1'b1;
    sbIf.st_valid = 1'b0;
    sbIf.st_adr   = '0;
    sbIf.st_data  = '0;
    sbIf.ld_req   = 1'b0;
    sbIf.ld_adr   = '0;
    for (int i = 0; i < 256; i++) begin
      envMem[i] = 8'($urandom);
      refMem[i] = envMem[i];
    end
    @(posedge clk);
    #1;

    // Reset then idle.
    doCycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
    doCycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
    idle();

    // Two stores drain in consecutive cycles.
    store(32'h10, 32'hDEAD_BEEF);
    store(32'h20, 32'h1122_3344);
    idle();
    idle();
    checkVal("bytes_0x10", envRead(32'h10), 32'hDEAD_BEEF);
    checkVal("bytes_0x20", envRead(32'h20), 32'h1122_3344);

    // Store attempts while a load is held, then a plain miss.
    for (int i = 0; i < 4; i++) doCycle(1'b1, 32'h30 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b1, 32'h8, 1'b0);
    load(32'h8);

    // Forwarding of the youngest matching store.
    store(32'h40, 32'hAAAA_0001);
    store(32'h40, 32'hBBBB_0002);
    load(32'h40);
    idle();

    // Partial overlap stalls, a one-cycle bubble drains, then the reload misses.
    store(32'h40, 32'h5566_7788);
    load(32'h42);
    idle();
    load(32'h42);

    // Partial overlap across the address wrap in both directions.
    store(32'hFFFF_FFFF, 32'h0102_0304);
    load(32'h0000_0001);
    idle();
    store(32'h0000_0001, 32'h0A0B_0C0D);
    load(32'hFFFF_FFFE);
    idle();

    // Reset with a store still pending: it must never reach memory.
    preWord = refRead(32'h88);
    store(32'h80, 32'h1111_1111);
    store(32'h84, 32'h2222_2222);
    store(32'h88, 32'h3333_3333);
    doCycle(1'b0, '0, '0, 1'b1, 32'h0, 1'b1);
    idle();
    idle();
    checkVal("undrained_0x88", envRead(32'h88), preWord);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      op = $urandom_range(0, 99);
      if (op < 45)      doCycle(1'b1, randAdr(), $urandom, 1'b0, '0, 1'b0);
      else if (op < 85) doCycle(1'b0, '0, '0, 1'b1, randAdr(), 1'b0);
      else if (op < 96) idle();
      else if (op < 99) doCycle(1'b1, randAdr(), $urandom, 1'b1, randAdr(), 1'b0);
      else              doCycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
    end
    for (int i = 0; i < 4; i++) idle();

    diffs = 0;
    for (int i = 0; i < 256; i++) if (envMem[i] !== refMem[i]) diffs++;
    checkVal("mem_image", 32'(diffs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
